// File: rtl/bfa_serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract engine.
//   master : controller side, drives start/op/a/b, observes status and result
//   slave  : engine side, receives the request, returns busy/done/result/flags
interface bfa_serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cflag;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cflag, ovf, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cflag, ovf, zero
    );
endinterface

// File: rtl/bfa_serial_addsub.sv
// Bit-serial add/subtract engine: one full-adder cell, LSB first, one bit per
// clock. Subtraction is A + ~B + 1 (B inverted at latch time, carry preset to 1).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bfa_serial_addsub_if (start/op/a/b in,
//           busy/done/result/cflag/ovf/zero out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result/flags hold the last completion
// SHIFT | one bit pair per clock through the adder cell, WIDTH cycles
module bfa_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bfa_serial_addsub_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, acc_q;
    logic             carry_q, opr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, cflag_q, ovf_q, zero_q;
    logic [WIDTH-1:0] result_q;

    // Full-adder cell and the accumulator value it would produce this cycle.
    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] acc_d;

    assign sum_bit = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    assign acc_d   = {sum_bit, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            opr_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cflag_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.op ? ~bus.b : bus.b;
                        opr_q   <= bus.op;
                        carry_q <= bus.op;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry_q <= carry_d;
                    acc_q   <= acc_d;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        // MSB edge: carry_q is the carry into the MSB,
                        // carry_d the carry out of it.
                        result_q <= acc_d;
                        cflag_q  <= opr_q ? ~carry_d : carry_d;
                        ovf_q    <= carry_q ^ carry_d;
                        zero_q   <= (acc_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cflag  = cflag_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: doc/bfa_serial_addsub.md
Name: bfa_serial_addsub

Overview:
- Bit-serial add/subtract engine built around a single full-adder cell, the same cell as the BFA.
- Each clock, one bit pair plus the registered carry passes through the cell, LSB first.
- Subtraction is A + ~B + 1: the B bit is inverted before the cell and the carry is preset to 1.
- Sits beside the combinational BFA as the area-minimal sequential arithmetic unit, with a start/done handshake toward the controller.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  1  0=add (A+B), 1=subtract (A-B); latched with the operands
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when the result registers update
- result  out  WIDTH  sum/difference; held until the next completion
- cflag  out  1  add: carry-out; sub: borrow (1 when A<B unsigned)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  result==0

Behaviour:
- States: IDLE, SHIFT.
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, cflag=0, ovf=0, zero=0. Operand shift registers, carry and bit counter are cleared.
- IDLE, start=1 at edge k (accept):
  - latch a→SA, (op ? ~b : b)→SB, op→OPR;
  - carry ← op;
  - cnt ← WIDTH-1;
  - state ← SHIFT, busy=1.
- SHIFT, each edge:
  - s = SA[0]^SB[0]^carry;
  - carry ← majority(SA[0], SB[0], carry);
  - shift s into the MSB of an internal accumulator, shifting right;
  - SA, SB shift right;
  - cnt decrements.
  - The cnt=0 edge processes the MSB. On that same edge:
    - result ← final accumulator;
    - cflag ← OPR ? ~carry_next : carry_next;
    - ovf ← carry into MSB XOR carry_next;
    - zero ← (final accumulator==0);
    - done ← 1, busy ← 0, state ← IDLE.
- Latency: start accepted at edge k → done=1 and result valid during the cycle after edge k+WIDTH. Exactly WIDTH SHIFT cycles.
- done is high for exactly one cycle and cleared at the next edge unconditionally.
- start while busy=1 is ignored: no queuing, operands not re-latched.
- start in the done cycle (busy=0) is accepted. Back-to-back throughput is one operation per WIDTH+1 cycles.
- result/cflag/ovf/zero change only on completion edges or reset. They stay stable through a subsequent operation until its done.
- a, b, op may change freely after acceptance without affecting the running operation.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no done pulse; the partial result is discarded.
- No X propagation: every register has a reset value.

Test Plan (WIDTH=8):
- Sub 0x05−0x03, start at edge k → done high after edge k+8 only; result=0x02, cflag=0, ovf=0, zero=0; busy high for exactly 8 cycles.
- Sub 0x03−0x05 → result=0xFE, cflag=1 (borrow), ovf=0. Sub 0x80−0x01 → result=0x7F, cflag=0, ovf=1.
- Add 0xFF+0x01 → result=0x00, cflag=1, zero=1, ovf=0. Add 0x7F+0x01 → result=0x80, ovf=1, cflag=0.
- Start pulsed again at cycle 3 of a busy op with different a/b → ignored; the first op's result is unchanged. Start asserted in the done cycle → accepted, second done exactly 9 cycles after the first.
- Operands/op changed every cycle during SHIFT → result matches the values latched at accept.
- rst_n low for 1 cycle at SHIFT cycle 4 → busy=0 and all outputs 0 immediately (asynchronous); no done. A new start then completes normally (0x0A−0x0A → result=0x00, zero=1, cflag=0).
